// File: rtl/phy_pkg.sv
// Shared PHY definitions: link-state encoding and transmit-path defaults.
package phy_pkg;

  typedef enum logic [1:0] {
    StDown  = 2'd0,
    StTrain = 2'd1,
    StUp    = 2'd2
  } link_state_e;

  localparam logic [31:0] IdleWordDefault    = 32'hBCBCBCBC;
  localparam int unsigned TrainCyclesDefault = 4;
  localparam int unsigned TrainCntW          = 4;

endpackage

// File: rtl/phy_link_fsm.sv
// Link-state FSM with training counter; flags the TRAIN->UP edge so the
// datapath can realign its stripe pointer.
module phy_link_fsm
  import phy_pkg::*;
#(
  parameter int unsigned TRAIN_CYCLES = TrainCyclesDefault
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic [1:0]  mask,
  output link_state_e state,
  output logic [1:0]  mask_q,
  output logic        enter_up,
  output logic        link_up
);

  localparam logic [TrainCntW-1:0] CntLast = TrainCntW'(TRAIN_CYCLES - 1);

  link_state_e          state_q, state_d;
  logic [1:0]           mask_r, mask_d;
  logic [TrainCntW-1:0] cnt_q, cnt_d;
  logic                 link_up_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_r;
    cnt_d    = cnt_q;
    enter_up = 1'b0;
    case (state_q)
      StDown: begin
        if (mask != 2'b00) begin
          state_d = StTrain;
          mask_d  = mask;
          cnt_d   = '0;
        end
      end
      StTrain: begin
        if (mask == 2'b00) begin
          state_d = StDown;
          mask_d  = 2'b00;
          cnt_d   = '0;
        end else if (mask != mask_r) begin
          mask_d = mask;
          cnt_d  = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = StUp;
          cnt_d    = '0;
          enter_up = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StUp: begin
        if (mask == 2'b00) begin
          state_d = StDown;
          mask_d  = 2'b00;
        end else if (mask != mask_r) begin
          state_d = StTrain;
          mask_d  = mask;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StDown;
        mask_d  = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q   <= StDown;
      mask_r    <= 2'b00;
      cnt_q     <= '0;
      link_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_r    <= mask_d;
      cnt_q     <= cnt_d;
      link_up_q <= (state_d == StUp);
    end
  end

  assign state   = state_q;
  assign mask_q  = mask_r;
  assign link_up = link_up_q;

endmodule

// File: rtl/phy_link_ctrl.sv
// Lane controller: stripes words across active lanes while the link is up and
// diverts them to the recirculation path otherwise.
module phy_link_ctrl
  import phy_pkg::*;
#(
  parameter int unsigned TRAIN_CYCLES = TrainCyclesDefault,
  parameter logic [31:0] IDLE_WORD    = IdleWordDefault
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        active_lane0,
  input  logic        active_lane1,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  output logic        lane0_valid,
  output logic [31:0] lane0_data,
  output logic        lane1_valid,
  output logic [31:0] lane1_data,
  output logic        recirc_valid,
  output logic [31:0] recirc_data,
  output logic        link_up,
  output logic [1:0]  state,
  output logic [15:0] words_sent
);

  link_state_e fsm_state;
  logic [1:0]  mask_q;
  logic        enter_up;

  phy_link_fsm #(
    .TRAIN_CYCLES(TRAIN_CYCLES)
  ) u_fsm (
    .clk_f   (clk_f),
    .reset   (reset),
    .mask    ({active_lane1, active_lane0}),
    .state   (fsm_state),
    .mask_q  (mask_q),
    .enter_up(enter_up),
    .link_up (link_up)
  );

  logic        ptr_q, ptr_d;
  logic [15:0] ws_q, ws_d;
  logic        l0v_q, l0v_d, l1v_q, l1v_d, rv_q, rv_d;
  logic [31:0] l0d_q, l0d_d, l1d_q, l1d_d, rd_q, rd_d;

  // Routing keys off the pre-edge state so a word arriving on a transition
  // cycle follows the old link state.
  always_comb begin
    l0v_d = 1'b0;
    l0d_d = IDLE_WORD;
    l1v_d = 1'b0;
    l1d_d = IDLE_WORD;
    rv_d  = 1'b0;
    rd_d  = '0;
    ptr_d = ptr_q;
    ws_d  = ws_q;
    if (enter_up) ptr_d = 1'b0;
    if (valid_in) begin
      if (fsm_state != StUp) begin
        rv_d = 1'b1;
        rd_d = data_in;
      end else begin
        ws_d = ws_q + 16'd1;
        case (mask_q)
          2'b11: begin
            if (ptr_q) begin
              l1v_d = 1'b1;
              l1d_d = data_in;
            end else begin
              l0v_d = 1'b1;
              l0d_d = data_in;
            end
            ptr_d = ~ptr_q;
          end
          2'b10: begin
            l1v_d = 1'b1;
            l1d_d = data_in;
          end
          default: begin
            l0v_d = 1'b1;
            l0d_d = data_in;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
      ws_q  <= '0;
      l0v_q <= 1'b0;
      l0d_q <= IDLE_WORD;
      l1v_q <= 1'b0;
      l1d_q <= IDLE_WORD;
      rv_q  <= 1'b0;
      rd_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      ws_q  <= ws_d;
      l0v_q <= l0v_d;
      l0d_q <= l0d_d;
      l1v_q <= l1v_d;
      l1d_q <= l1d_d;
      rv_q  <= rv_d;
      rd_q  <= rd_d;
    end
  end

  assign lane0_valid  = l0v_q;
  assign lane0_data   = l0d_q;
  assign lane1_valid  = l1v_q;
  assign lane1_data   = l1d_q;
  assign recirc_valid = rv_q;
  assign recirc_data  = rd_q;
  assign words_sent   = ws_q;
  assign state        = fsm_state;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bench for phy_link_ctrl with default parameters.
module tb_phy_link_ctrl;

  localparam logic [31:0] Idle = 32'hBCBCBCBC;

  logic        clk_f = 1'b0;
  logic        reset = 1'b0;
  logic        active_lane0 = 1'b0, active_lane1 = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        lane0_valid, lane1_valid, recirc_valid, link_up;
  logic [31:0] lane0_data, lane1_data, recirc_data;
  logic [1:0]  state;
  logic [15:0] words_sent;

  int n_checks = 0;
  int n_fail   = 0;

  phy_link_ctrl dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .active_lane0(active_lane0),
    .active_lane1(active_lane1),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .lane0_valid (lane0_valid),
    .lane0_data  (lane0_data),
    .lane1_valid (lane1_valid),
    .lane1_data  (lane1_data),
    .recirc_valid(recirc_valid),
    .recirc_data (recirc_data),
    .link_up     (link_up),
    .state       (state),
    .words_sent  (words_sent)
  );

  always #5 clk_f = ~clk_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_f);
    #1;
    check("onehot", 32'($countones({lane0_valid, lane1_valid, recirc_valid}) <= 1), 32'd1);
  endtask

  task automatic set_mask(input logic [1:0] m);
    {active_lane1, active_lane0} = m;
  endtask

  // Exactly one lane carries d; the other lane and recirc are idle.
  task automatic chk_lane(input string tag, input int lane, input logic [31:0] d);
    check({tag, "_l0v"}, 32'(lane0_valid), 32'(lane == 0));
    check({tag, "_l0d"}, lane0_data, (lane == 0) ? d : Idle);
    check({tag, "_l1v"}, 32'(lane1_valid), 32'(lane == 1));
    check({tag, "_l1d"}, lane1_data, (lane == 1) ? d : Idle);
    check({tag, "_rv"}, 32'(recirc_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_link"}, 32'(link_up), 32'd0);
    check({tag, "_ws"}, 32'(words_sent), 32'd0);
    check({tag, "_rd"}, recirc_data, 32'd0);
    chk_lane(tag, 2, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          exp_ptr;
    int          exp_ws;

    // Reset
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_async");
    @(posedge clk_f);
    @(posedge clk_f);
    #1 chk_reset_vals("rst_hold");
    reset = 1'b0;

    // Recirculation with empty mask
    set_mask(2'b00);
    for (int i = 0; i < 10; i++) begin
      d = 32'h320FE14F * (i + 1);
      valid_in = 1'b1;
      data_in  = d;
      step();
      check("rc_valid", 32'(recirc_valid), 32'd1);
      check("rc_data", recirc_data, d);
      check("rc_l0v", 32'(lane0_valid), 32'd0);
      check("rc_l1d", lane1_data, Idle);
      check("rc_ws", 32'(words_sent), 32'd0);
      check("rc_state", 32'(state), 32'd0);
    end
    valid_in = 1'b0;
    step();
    check("rc_off_v", 32'(recirc_valid), 32'd0);
    check("rc_off_d", recirc_data, 32'd0);

    // Training to UP with both lanes
    set_mask(2'b11);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("tr_state", 32'(state), (k < 5) ? 32'd1 : 32'd2);
      check("tr_link", 32'(link_up), 32'(k == 5));
    end

    // Striping
    for (int i = 0; i < 35; i++) begin
      d = 32'h002F190A * (i + 1);
      valid_in = 1'b1;
      data_in  = d;
      step();
      chk_lane("stripe", i % 2, d);
    end
    valid_in = 1'b0;
    step();
    chk_lane("stripe_idle", 2, 32'd0);
    check("stripe_ws", 32'(words_sent), 32'd35);

    // Mask change 11 -> 01; pointer sits on lane1 after 35 words
    set_mask(2'b01);
    valid_in = 1'b1;
    data_in  = 32'hCAFE0001;
    step();
    chk_lane("mc_switch", 1, 32'hCAFE0001);
    check("mc_state", 32'(state), 32'd1);
    check("mc_link", 32'(link_up), 32'd0);
    check("mc_ws", 32'(words_sent), 32'd36);
    for (int k = 1; k <= 4; k++) begin
      d = 32'hCAFE0010 + k;
      data_in = d;
      step();
      check("mc_rc_v", 32'(recirc_valid), 32'd1);
      check("mc_rc_d", recirc_data, d);
      check("mc_tr_state", 32'(state), (k < 4) ? 32'd1 : 32'd2);
    end
    for (int k = 0; k < 3; k++) begin
      d = 32'h5A5A0000 + k;
      data_in = d;
      step();
      chk_lane("mc_up", 0, d);
    end
    check("mc_ws2", 32'(words_sent), 32'd39);

    // Retrain on 11, then sparse traffic
    set_mask(2'b11);
    valid_in = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("sp_up", 32'(state), 32'd2);
    exp_ptr = 0;
    exp_ws  = 39;
    for (int i = 0; i < 20; i++) begin
      d = 32'h12345678 + 32'h9E3779B9 * i;
      data_in  = d;
      valid_in = d[3];
      step();
      if (d[3]) begin
        chk_lane("sparse", exp_ptr, d);
        exp_ptr = 1 - exp_ptr;
        exp_ws++;
      end else begin
        chk_lane("sparse_idle", 2, 32'd0);
      end
    end
    check("sp_ws", 32'(words_sent), 32'(exp_ws));

    // Asynchronous reset mid-UP with traffic
    valid_in = 1'b1;
    data_in  = 32'h0321AE4F;
    step();
    step();
    check("pre_rst_link", 32'(link_up), 32'd1);
    check("pre_rst_busy", 32'(lane0_valid | lane1_valid), 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(posedge clk_f);
    #1 reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("rr_link", 32'(link_up), 32'(k == 5));
      check("rr_rc_v", 32'(recirc_valid), 32'(k <= 5));
      if (k == 1) check("rr_state1", 32'(state), 32'd1);
    end

    // words_sent wrap
    for (int i = 1; i <= 65537; i++) begin
      @(posedge clk_f);
      #1;
      if (i == 65535) check("wrap_ffff", 32'(words_sent), 32'h0000FFFF);
      if (i == 65536) check("wrap_0", 32'(words_sent), 32'd0);
    end
    check("wrap_1", 32'(words_sent), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
